// File: rtl/cipher_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cipher_pkg
//  Purpose  : Shared ASCII constants, state encoding and key helpers for the
//             Caesar/Vigenere cipher blocks.
//  Revision : 1.0  initial release
// ============================================================================
package cipher_pkg;

  localparam logic [7:0] ASCII_A       = 8'd97;
  localparam logic [7:0] ASCII_Z       = 8'd122;
  localparam logic [7:0] ASCII_SPACE   = 8'd32;
  localparam logic [4:0] ALPHA_LEN     = 5'd26;
  localparam int         KEY_CHARS_MAX = 6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Non-lowercase key characters contribute no shift.
  function automatic logic [4:0] key_shift(input logic [7:0] ch);
    return (ch >= ASCII_A && ch <= ASCII_Z) ? 5'(ch - ASCII_A) : 5'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod26_sub.sv
`default_nettype none
// ============================================================================
//  Module   : mod26_sub
//  Purpose  : Combinational (c - k) mod 26 on 5-bit alphabet indices.
//  Revision : 1.0  initial release
// ============================================================================
module mod26_sub
  import cipher_pkg::*;
(
  input  logic [4:0] i_c,
  input  logic [4:0] i_k,
  output logic [4:0] o_diff
);

  logic signed [5:0] w_diff;

  assign w_diff = $signed({1'b0, i_c}) - $signed({1'b0, i_k});
  // Low five bits plus 26 wrap modulo 32 to the correct residue.
  assign o_diff = w_diff[5] ? (w_diff[4:0] + ALPHA_LEN) : w_diff[4:0];

endmodule
`default_nettype wire

// File: rtl/vigenere_decrypt.sv
`default_nettype none
// ============================================================================
//  Module   : vigenere_decrypt
//  Purpose  : Streaming Vigenere decipher with valid/ready handshake and a
//             one-cycle registered output.
//  Revision : 1.0  initial release
// ============================================================================
module vigenere_decrypt
  import cipher_pkg::*;
#(
  parameter int KEY_CHARS = 6
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [8*KEY_CHARS-1:0] key,
  input  logic [2:0]             key_len,
  input  logic                   load,
  input  logic                   in_valid,
  input  logic [7:0]             in_char,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [7:0]             out_char,
  input  logic                   out_ready,
  output logic [15:0]            char_count
);

  state_t                   r_state;
  logic [8*KEY_CHARS-1:0]   r_key;
  logic [2:0]               r_key_len;
  logic [2:0]               r_key_idx;
  logic                     r_out_valid;
  logic [7:0]               r_out_char;
  logic [15:0]              r_char_count;

  logic [4:0]               w_shift [KEY_CHARS];
  logic [2:0]               w_len_clamped;
  logic [2:0]               w_idx_next;
  logic                     w_in_ready;
  logic                     w_xfer;
  logic                     w_is_letter;
  logic [4:0]               w_plain_idx;
  logic [7:0]               w_out_char;

  for (genvar i = 0; i < KEY_CHARS; i++) begin : g_shift
    assign w_shift[i] = key_shift(r_key[8*i +: 8]);
  end

  assign w_len_clamped = (key_len == 3'd0)            ? 3'd1 :
                         (key_len > 3'(KEY_CHARS))    ? 3'(KEY_CHARS) : key_len;
  assign w_idx_next    = (r_key_idx == r_key_len - 3'd1) ? 3'd0 : r_key_idx + 3'd1;

  assign w_in_ready  = (r_state == RUN) && !load && (!r_out_valid || out_ready);
  assign w_xfer      = in_valid && w_in_ready;
  assign w_is_letter = (in_char >= ASCII_A) && (in_char <= ASCII_Z);

  mod26_sub u_mod26_sub (
    .i_c    (5'(in_char - ASCII_A)),
    .i_k    (w_shift[r_key_idx]),
    .o_diff (w_plain_idx)
  );

  // Spaces and all non-letters decode to a space without consuming key.
  assign w_out_char = w_is_letter ? (ASCII_A + {3'b000, w_plain_idx}) : ASCII_SPACE;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_key        <= '0;
      r_key_len    <= 3'd1;
      r_key_idx    <= 3'd0;
      r_out_valid  <= 1'b0;
      r_out_char   <= ASCII_SPACE;
      r_char_count <= 16'd0;
    end else if (load) begin
      r_state      <= RUN;
      r_key        <= key;
      r_key_len    <= w_len_clamped;
      r_key_idx    <= 3'd0;
      r_out_valid  <= 1'b0;
      r_out_char   <= ASCII_SPACE;
      r_char_count <= 16'd0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_char  <= w_out_char;
      if (w_is_letter) begin
        r_key_idx    <= w_idx_next;
        r_char_count <= r_char_count + 16'd1;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_char   = r_out_char;
  assign char_count = r_char_count;

endmodule
`default_nettype wire

// File: tb/tb_vigenere_decrypt.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vigenere_decrypt
//  Purpose  : Self-checking bench for vigenere_decrypt against a
//             character-level Vigenere reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vigenere_decrypt;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [47:0] key = '0;
  logic [2:0]  key_len = '0;
  logic        load = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_char = '0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_char;
  logic        out_ready = 1'b1;
  logic [15:0] char_count;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit          m_run;
  int          m_shift [6];
  int          m_len;
  int          m_idx;
  logic [15:0] m_cnt;
  bit          m_ov;
  logic [7:0]  m_oc;
  logic [7:0]  got [$];

  localparam logic [47:0] KEY_LEMON = 48'h00_6E_6F_6D_65_6C;

  vigenere_decrypt #(.KEY_CHARS(6)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .key        (key),
    .key_len    (key_len),
    .load       (load),
    .in_valid   (in_valid),
    .in_char    (in_char),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_char   (out_char),
    .out_ready  (out_ready),
    .char_count (char_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_dec(input logic [7:0] b);
    int c, p;
    if (b >= 8'd97 && b <= 8'd122) begin
      c     = int'(b) - 97;
      p     = (c - m_shift[m_idx] + 26) % 26;
      m_idx = (m_idx + 1) % m_len;
      m_cnt = m_cnt + 16'd1;
      return 8'(p + 97);
    end
    return 8'd32;
  endfunction

  task automatic model_reset();
    m_run = 0; m_len = 1; m_idx = 0; m_cnt = '0; m_ov = 0; m_oc = 8'd32;
    for (int i = 0; i < 6; i++) m_shift[i] = 0;
  endtask

  task automatic model_load();
    logic [7:0] ch;
    m_run = 1; m_idx = 0; m_cnt = '0; m_ov = 0;
    for (int i = 0; i < 6; i++) begin
      ch = key[8*i +: 8];
      m_shift[i] = (ch >= 8'd97 && ch <= 8'd122) ? int'(ch) - 97 : 0;
    end
    m_len = (key_len == 3'd0) ? 1 : (key_len > 3'd6) ? 6 : int'(key_len);
  endtask

  // One clock: compare settled outputs with the model, then advance both.
  task automatic step();
    bit exp_rdy, xfer;
    #1;
    exp_rdy = m_run && !load && (!m_ov || out_ready);
    xfer    = exp_rdy && in_valid;
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, m_ov);
    check("char_count", char_count, m_cnt);
    if (m_ov) check("out_char", out_char, m_oc);
    if (m_ov && out_ready) got.push_back(out_char);
    if (load)           model_load();
    else if (xfer)      begin m_oc = model_dec(in_char); m_ov = 1; end
    else if (out_ready) m_ov = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic set_key(input logic [47:0] k, input logic [2:0] l);
    key = k; key_len = l; load = 1; in_valid = 0;
    step();
    load = 0;
  endtask

  task automatic send(input string s);
    got.delete();
    out_ready = 1;
    for (int i = 0; i < s.len(); i++) begin
      in_valid = 1; in_char = s[i];
      step();
    end
    in_valid = 0;
    step();
  endtask

  task automatic check_str(input string tag, input string exp);
    check({tag, "_len"}, got.size(), exp.len());
    for (int i = 0; i < exp.len() && i < got.size(); i++)
      check(tag, got[i], exp[i]);
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    resetn = 0;
    #1;
    check("rst_out_char", out_char, 8'd32);
    check("rst_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    resetn = 1;

    // IDLE ignores input until the first load
    in_valid = 1; in_char = "a";
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_out_char", out_char, 8'd32);
    end
    in_valid = 0;

    set_key(48'h62, 3'd1);
    send("ifmmp");
    check_str("caesar", "hello");
    check("caesar_cnt", char_count, 16'd5);

    set_key(48'h64, 3'd1);
    send("acd");
    check_str("wrap", "xza");

    set_key(KEY_LEMON, 3'd5);
    send("lxfopv efrnhr");
    check_str("lemon", "attack atdawn");
    check("lemon_cnt", char_count, 16'd12);

    set_key(KEY_LEMON, 3'd5);
    send("a#a");
    check_str("nonalpha", "p w");

    set_key(KEY_LEMON, 3'd0);
    send("aa");
    check_str("len0", "pp");

    // backpressure: held output, nothing lost or duplicated
    set_key(48'h62, 3'd1);
    got.delete();
    out_ready = 0; in_valid = 1; in_char = "c";
    step();
    in_char = "d";
    for (int i = 0; i < 3; i++) step();
    out_ready = 1;
    step();
    in_valid = 0;
    step();
    check_str("bp", "bc");

    // load while an output is stalled
    out_ready = 0; in_valid = 1; in_char = "c";
    step();
    in_valid = 0;
    set_key(48'h64, 3'd1);
    check("ml_out_valid", out_valid, 1'b0);
    check("ml_cnt", char_count, 16'd0);
    send("d");
    check_str("midload", "a");

    // asynchronous reset mid-stream
    out_ready = 0; in_valid = 1; in_char = "e";
    step();
    resetn = 0;
    #1;
    check("areset_valid", out_valid, 1'b0);
    check("areset_ready", in_ready, 1'b0);
    check("areset_char", out_char, 8'd32);
    model_reset();
    @(posedge clk); #1;
    resetn = 1;
    for (int i = 0; i < 3; i++) step();

    // randomized traffic with occasional reloads
    set_key(KEY_LEMON, 3'd5);
    for (int n = 0; n < 2000; n++) begin
      int r;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      r = $urandom % 10;
      if (r < 7)       in_char = 8'(97 + $urandom % 26);
      else if (r == 7) in_char = 8'd32;
      else             in_char = 8'($urandom % 256);
      load = ($urandom % 100) == 0;
      if (load) begin
        for (int i = 0; i < 6; i++)
          key[8*i +: 8] = (($urandom % 10) != 0) ? 8'(97 + $urandom % 26) : 8'($urandom % 256);
        key_len = 3'($urandom % 8);
      end
      step();
    end
    load = 0; in_valid = 0; out_ready = 1;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
